// File: rtl/md_stall_ctrl.sv
// Multiply/divide sequencer for SimpleProcessor: starts multdiv, stalls fetch, and writes back the result or rstatus.
// Optional busy-cycle timeout is enabled with `define MD_TIMEOUT_EN.
module md_stall_ctrl #(
    parameter logic [4:0] MULT_OP = 5'b00110,
    parameter logic [4:0] DIV_OP  = 5'b00111,
    parameter int         CNT_W   = 7,
    parameter int         TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic [4:0]       aluop,
    input  logic [4:0]       rd,
    input  logic             md_ready,
    input  logic             md_exception,
    output logic             ctrl_mult,
    output logic             ctrl_div,
    output logic             stall,
    output logic             busy,
    output logic             wb_en,
    output logic [4:0]       wb_rd,
    output logic             wb_sel_md,
    output logic [31:0]      wb_status,
    output logic [CNT_W-1:0] md_latency
);

    typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;

`ifdef MD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       rd_q;
    logic             is_div_q;
    logic             exc_q;
    logic             to_q;
    logic             is_md;
    logic             timeout_hit;

    assign is_md       = (opcode == 5'b00000) && ((aluop == MULT_OP) || (aluop == DIV_OP));
    assign cnt_inc     = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
    assign timeout_hit = TO_EN && (cnt == TO_LAST);

    // stall is the only output with a combinational input path: the
    // instruction must be frozen in the very cycle it is decoded.
    assign stall = (state == IDLE) ? is_md : (state != WB);
    assign busy  = (state != IDLE);

    // Remaining outputs decode registered state only.
    assign ctrl_mult = (state == START) && !is_div_q;
    assign ctrl_div  = (state == START) && is_div_q;
    assign wb_en     = (state == WB) && (exc_q || (rd_q != 5'd0));
    assign wb_rd     = (state != WB) ? 5'd0 : (exc_q ? 5'd30 : rd_q);
    assign wb_sel_md = (state == WB) && !exc_q;

    always_comb begin
        wb_status = 32'd0;
        if (state == WB && exc_q) begin
            if (to_q)
                wb_status = 32'd6;
            else
                wb_status = is_div_q ? 32'd5 : 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_q       <= 5'd0;
            is_div_q   <= 1'b0;
            exc_q      <= 1'b0;
            to_q       <= 1'b0;
            md_latency <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_md) begin
                        rd_q     <= rd;
                        is_div_q <= (aluop == DIV_OP);
                        cnt      <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (md_ready) begin
                        exc_q      <= md_exception;
                        to_q       <= 1'b0;
                        md_latency <= cnt_inc;
                        state      <= WB;
                    end else if (timeout_hit) begin
                        exc_q      <= 1'b1;
                        to_q       <= 1'b1;
                        md_latency <= cnt_inc;
                        state      <= WB;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WB: begin
                    // The md instruction is still on opcode here; returning
                    // to IDLE unconditionally keeps it from retriggering.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Bench for md_stall_ctrl: directed and random mult/div transactions checked
// against a cycle-count model derived from the operation's ready delay.
module tb_md_stall_ctrl;

`ifdef MD_TIMEOUT_EN
    localparam int TO    = 8;
    localparam bit TO_ON = 1'b1;
`else
    localparam int TO    = 64;
    localparam bit TO_ON = 1'b0;
`endif
    localparam int LAT_MAX = 127;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  opcode = 5'd1;
    logic [4:0]  aluop = 5'd0;
    logic [4:0]  rd = 5'd0;
    logic        md_ready = 1'b0;
    logic        md_exception = 1'b0;
    logic        ctrl_mult, ctrl_div, stall, busy, wb_en, wb_sel_md;
    logic [4:0]  wb_rd;
    logic [31:0] wb_status;
    logic [6:0]  md_latency;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [38:0] exp_q[$];
    logic [6:0]  last_lat = 7'd0;

    md_stall_ctrl #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .aluop(aluop), .rd(rd),
        .md_ready(md_ready), .md_exception(md_exception),
        .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div), .stall(stall), .busy(busy),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_sel_md(wb_sel_md), .wb_status(wb_status),
        .md_latency(md_latency)
    );

    // clock / reset
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [38:0] wb_vec();
        return {wb_en, wb_sel_md, wb_rd, wb_status};
    endfunction

    task automatic drive_nop();
        opcode = 5'($urandom_range(0, 31));
        aluop  = 5'($urandom_range(0, 31));
        if (opcode == 5'd0 && (aluop == 5'd6 || aluop == 5'd7))
            aluop = 5'd0;
        rd = 5'($urandom_range(0, 31));
        md_ready = 1'($urandom_range(0, 1));
        md_exception = 1'($urandom_range(0, 1));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ctrl"}, {ctrl_mult, ctrl_div}, 0);
        check({tag, "_wb"}, wb_vec(), 0);
        check({tag, "_lat"}, md_latency, last_lat);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        drive_nop();
        #1;
        check_quiet("idle");
    endtask

    // One md instruction: k is the BUSY cycle (1-based) in which md_ready rises.
    task automatic run_op(input bit is_div, input logic [4:0] rd_v, input int k,
                          input bit exc, input bit noise);
        bit         timed_out;
        int         eff;
        int         wb_c;
        logic [6:0] lat;
        timed_out = TO_ON && (k > TO);
        eff  = timed_out ? TO : k;
        wb_c = 2 + eff;
        lat  = 7'((eff > LAT_MAX) ? LAT_MAX : eff);
        if (timed_out)
            exp_q.push_back({1'b1, 1'b0, 5'd30, 32'd6});
        else if (exc)
            exp_q.push_back({1'b1, 1'b0, 5'd30, is_div ? 32'd5 : 32'd4});
        else
            exp_q.push_back({rd_v != 5'd0, 1'b1, rd_v, 32'd0});
        for (int c = 0; c <= wb_c; c++) begin
            @(negedge clock);
            opcode = 5'd0;
            aluop  = is_div ? 5'd7 : 5'd6;
            rd     = (c == 0) ? rd_v : 5'($urandom_range(0, 31));
            if (c == 1)
                md_ready = noise;
            else
                md_ready = (c >= 2) && (c - 1 == k);
            md_exception = (c >= 2 && c - 1 == k) ? exc : 1'($urandom_range(0, 1));
            #1;
            check("stall", stall, c != wb_c);
            check("busy", busy, c != 0);
            check("ctrl_mult", ctrl_mult, c == 1 && !is_div);
            check("ctrl_div", ctrl_div, c == 1 && is_div);
            if (c == wb_c) begin
                check("wb", wb_vec(), exp_q.pop_front());
                check("latency", md_latency, lat);
                last_lat = lat;
            end else begin
                check("wb_off", wb_vec(), 0);
                check("latency_hold", md_latency, last_lat);
            end
        end
    endtask

    task automatic reset_mid();
        for (int c = 0; c <= 6; c++) begin
            @(negedge clock);
            opcode = 5'd0;
            aluop = 5'd6;
            rd = 5'd9;
            md_ready = 1'b0;
            #1;
            check("pre_rst_busy", busy, c != 0);
        end
        @(negedge clock);
        drive_nop();
        reset = 1'b0;
        last_lat = 7'd0;
        #1;
        check_quiet("rst");
        opcode = 5'd0;
        aluop = 5'd7;
        #1;
        check("rst_stall_md", stall, 1);
        check("rst_busy_md", busy, 0);
        @(negedge clock);
        drive_nop();
        reset = 1'b1;
        #1;
        check_quiet("post_rst");
    endtask

    initial begin
        #1;
        check_quiet("por");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        idle_cycle();

        run_op(1'b0, 5'd3, 16, 1'b0, 1'b0);
        idle_cycle();
        run_op(1'b1, 5'd7, 5, 1'b1, 1'b1);
        run_op(1'b0, 5'd0, 4, 1'b0, 1'b0);
        run_op(1'b0, 5'd4, 3, 1'b0, 1'b0);
        run_op(1'b0, 5'd5, 3, 1'b0, 1'b0);
        run_op(1'b1, 5'd0, 1, 1'b1, 1'b0);
        run_op(1'b0, 5'd12, 1, 1'b0, 1'b1);
        run_op(1'b1, 5'd8, TO, 1'b0, 1'b0);
        run_op(1'b0, 5'd9, TO + 1, 1'b0, 1'b0);
        run_op(1'b0, 5'd6, 130, 1'b0, 1'b0);
        idle_cycle();
        reset_mid();

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                idle_cycle();
            run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom_range(1, 20), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
